// File: rtl/exception_sequencer_if.sv
// Purpose: groups the MEM-stage event inputs, the CP0 snapshot and the CP0-write/redirect outputs of the sequencer.
// Latency: none, wiring only.
// Backpressure: none here; the sequencer's stall output holds the pipeline.
interface exception_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             inst_valid;
  logic             exc_valid;
  logic [4:0]       exc_code;
  logic [WIDTH-1:0] exc_pc;
  logic             exc_bd;
  logic             exc_has_badv;
  logic [WIDTH-1:0] exc_badvaddr;
  logic             eret;
  logic [5:0]       hw_int;
  logic [WIDTH-1:0] status_in;
  logic [WIDTH-1:0] cause_in;
  logic [WIDTH-1:0] epc_in;
  logic             cp0_we;
  logic [4:0]       cp0_waddr;
  logic [WIDTH-1:0] cp0_wdata;
  logic             stall;
  logic             flush;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;

  // Pipeline / CP0 side: presents events and register values, consumes writes and redirects.
  modport master (
    output inst_valid, exc_valid, exc_code, exc_pc, exc_bd, exc_has_badv, exc_badvaddr,
    output eret, hw_int, status_in, cause_in, epc_in,
    input  cp0_we, cp0_waddr, cp0_wdata, stall, flush, redirect_valid, redirect_pc
  );

  // Sequencer side.
  modport slave (
    input  inst_valid, exc_valid, exc_code, exc_pc, exc_bd, exc_has_badv, exc_badvaddr,
    input  eret, hw_int, status_in, cause_in, epc_in,
    output cp0_we, cp0_waddr, cp0_wdata, stall, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exception_sequencer.sv
// Purpose: arbitrates interrupt > exception > ERET and sequences CP0 writes (one per cycle), then flushes and redirects.
// Latency: redirect 5 cycles after accept (BadVAddr), 4 (plain), one fewer with EXL already set; ERET 2 cycles.
// Backpressure: stall is held while not IDLE; events presented meanwhile are ignored and must be re-presented.
module exception_sequencer #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic clk,
  input  logic rst,
  exception_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    W_BADV,
    W_EPC,
    W_CAUSE,
    W_STATUS,
    E_STATUS,
    REDIRECT
  } state_t;

  state_t state, state_nxt;

  logic [4:0]       code_q;
  logic [WIDTH-1:0] pc_q;       // faulting PC, or the EPC target on ERET
  logic             bd_q;
  logic             has_badv_q;
  logic [WIDTH-1:0] badv_q;
  logic             exl_q;      // EXL was already set: keep the existing EPC
  logic             eret_q;

  logic [7:0] ip;
  logic       int_pend;
  logic       acc_int;
  logic       acc_exc;
  logic       acc_eret;
  logic       idle;

  // Pending-interrupt detection and event arbitration (only meaningful in IDLE).
  always_comb begin
    ip       = {bus.hw_int, bus.cause_in[9:8]};
    int_pend = (|(ip & bus.status_in[15:8])) & bus.status_in[0] & ~bus.status_in[1];
    idle     = (state == IDLE);
    acc_int  = idle & int_pend & bus.inst_valid;
    acc_exc  = idle & bus.exc_valid & bus.inst_valid & ~acc_int;
    acc_eret = idle & bus.eret & bus.inst_valid & ~bus.exc_valid & ~acc_int;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Capture the accepted event so the sequence is independent of later MEM contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q     <= '0;
      pc_q       <= '0;
      bd_q       <= 1'b0;
      has_badv_q <= 1'b0;
      badv_q     <= '0;
      exl_q      <= 1'b0;
      eret_q     <= 1'b0;
    end else if (acc_int || acc_exc || acc_eret) begin
      code_q     <= acc_exc ? bus.exc_code : 5'd0;
      pc_q       <= acc_eret ? bus.epc_in : bus.exc_pc;
      bd_q       <= acc_eret ? 1'b0 : bus.exc_bd;
      has_badv_q <= acc_exc & bus.exc_has_badv;
      badv_q     <= acc_exc ? bus.exc_badvaddr : '0;
      exl_q      <= acc_exc & bus.status_in[1];
      eret_q     <= acc_eret;
    end
  end

  // Next-state and per-state CP0 write / redirect outputs.
  always_comb begin
    state_nxt          = state;
    bus.cp0_we         = 1'b0;
    bus.cp0_waddr      = 5'd0;
    bus.cp0_wdata      = '0;
    bus.stall          = (state != IDLE);
    bus.flush          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    case (state)
      IDLE: begin
        if (acc_int) begin
          state_nxt = W_EPC;
        end else if (acc_exc) begin
          if (bus.exc_has_badv)      state_nxt = W_BADV;
          else if (bus.status_in[1]) state_nxt = W_CAUSE;
          else                       state_nxt = W_EPC;
        end else if (acc_eret) begin
          state_nxt = E_STATUS;
        end
      end
      W_BADV: begin
        bus.cp0_we    = 1'b1;
        bus.cp0_waddr = 5'd8;
        bus.cp0_wdata = badv_q;
        state_nxt     = exl_q ? W_CAUSE : W_EPC;
      end
      W_EPC: begin
        bus.cp0_we    = 1'b1;
        bus.cp0_waddr = 5'd14;
        bus.cp0_wdata = bd_q ? (pc_q - WIDTH'(4)) : pc_q;
        state_nxt     = W_CAUSE;
      end
      W_CAUSE: begin
        bus.cp0_we        = 1'b1;
        bus.cp0_waddr     = 5'd13;
        bus.cp0_wdata     = bus.cause_in;
        bus.cp0_wdata[31] = bd_q;
        bus.cp0_wdata[6:2] = code_q;
        state_nxt         = W_STATUS;
      end
      W_STATUS: begin
        bus.cp0_we       = 1'b1;
        bus.cp0_waddr    = 5'd12;
        bus.cp0_wdata    = bus.status_in;
        bus.cp0_wdata[1] = 1'b1;
        state_nxt        = REDIRECT;
      end
      E_STATUS: begin
        bus.cp0_we       = 1'b1;
        bus.cp0_waddr    = 5'd12;
        bus.cp0_wdata    = bus.status_in;
        bus.cp0_wdata[1] = 1'b0;
        state_nxt        = REDIRECT;
      end
      REDIRECT: begin
        bus.flush          = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = eret_q ? pc_q : EXC_VECTOR;
        state_nxt          = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_exception_sequencer.sv
// Purpose: directed scoreboard bench for exception_sequencer; stimulus pushes expected writes/redirects, a monitor pops and compares.
// Latency: expected cycle of every output is recorded and compared.
// Backpressure: stall length per sequence is measured and compared.
module tb_exception_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  typedef struct {
    bit          is_redir;
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  exception_sequencer_if #(.WIDTH(32)) bus();

  exception_sequencer #(.WIDTH(32), .EXC_VECTOR(32'hBFC00380)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write or redirect the DUT presents must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en && (bus.cp0_we || bus.redirect_valid)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output cyc=%0d we=%b addr=%0d data=%h redir=%b pc=%h required none",
                 cyc, bus.cp0_we, bus.cp0_waddr, bus.cp0_wdata, bus.redirect_valid, bus.redirect_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.is_redir) begin
          if (!(bus.redirect_valid && bus.flush && !bus.cp0_we && bus.stall &&
                bus.redirect_pc == e.data && cyc == e.cyc)) begin
            errors++;
            $display("FAIL redirect cyc=%0d rv=%b flush=%b we=%b stall=%b pc=%h required cyc=%0d pc=%h with flush, stall, no write",
                     cyc, bus.redirect_valid, bus.flush, bus.cp0_we, bus.stall, bus.redirect_pc, e.cyc, e.data);
          end
        end else begin
          if (!(bus.cp0_we && !bus.redirect_valid && bus.stall &&
                bus.cp0_waddr == e.addr && bus.cp0_wdata == e.data && cyc == e.cyc)) begin
            errors++;
            $display("FAIL cp0_write cyc=%0d we=%b rv=%b addr=%0d data=%h required cyc=%0d addr=%0d data=%h",
                     cyc, bus.cp0_we, bus.redirect_valid, bus.cp0_waddr, bus.cp0_wdata, e.cyc, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic push_w(input logic [4:0] addr, input logic [31:0] data, input int c);
    exp_t e;
    e.is_redir = 1'b0; e.addr = addr; e.data = data; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic push_r(input logic [31:0] pc, input int c);
    exp_t e;
    e.is_redir = 1'b1; e.addr = 5'd0; e.data = pc; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic clear_events();
    bus.inst_valid = 1'b0;
    bus.exc_valid  = 1'b0;
    bus.eret       = 1'b0;
    bus.hw_int     = 6'd0;
  endtask

  // Called #1 after a rising edge; the event is seen by the DUT in this cycle.
  task automatic present(input logic iv, input logic ev, input logic [4:0] code,
                         input logic [31:0] pc, input logic bd, input logic hb,
                         input logic [31:0] bv, input logic er, input logic [5:0] hw,
                         input logic [31:0] st, input logic [31:0] ca, input logic [31:0] ep,
                         output int acc);
    bus.inst_valid   = iv;
    bus.exc_valid    = ev;
    bus.exc_code     = code;
    bus.exc_pc       = pc;
    bus.exc_bd       = bd;
    bus.exc_has_badv = hb;
    bus.exc_badvaddr = bv;
    bus.eret         = er;
    bus.hw_int       = hw;
    bus.status_in    = st;
    bus.cause_in     = ca;
    bus.epc_in       = ep;
    acc = cyc;
  endtask

  // Drop the event after one cycle, measure how long stall stays high, and confirm all expectations were consumed.
  task automatic run_seq(input int exp_stall, input string name);
    int n = 0;
    bit done = 1'b0;
    @(posedge clk); #1;
    clear_events();
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.stall) begin
        n++;
        @(posedge clk); #1;
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout stall still high after 20 cycles, required low", name);
    end
    check({name, "_stall_cycles"}, n, exp_stall);
    check({name, "_sb_drained"}, sb.size(), 0);
  endtask

  initial begin
    int a;
    #100000;
    $display("FAIL watchdog simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int a;
    rst = 1'b1;
    clear_events();
    bus.exc_code = 5'd0; bus.exc_pc = '0; bus.exc_bd = 1'b0; bus.exc_has_badv = 1'b0;
    bus.exc_badvaddr = '0; bus.status_in = '0; bus.cause_in = '0; bus.epc_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    check("reset_outs",
          {bus.cp0_we, bus.stall, bus.flush, bus.redirect_valid, bus.cp0_waddr},
          32'd0);
    check("reset_wdata", bus.cp0_wdata, 32'd0);
    check("reset_redirect_pc", bus.redirect_pc, 32'd0);

    // Address error with BadVAddr.
    present(1, 1, 5'd4, 32'hBFC00100, 0, 1, 32'h00000013, 0, 6'd0, 32'h0040FF01, 32'h0, 32'h0, a);
    push_w(5'd8,  32'h00000013, a + 1);
    push_w(5'd14, 32'hBFC00100, a + 2);
    push_w(5'd13, 32'h00000010, a + 3);
    push_w(5'd12, 32'h0040FF03, a + 4);
    push_r(32'hBFC00380, a + 5);
    run_seq(5, "adel");

    // Syscall in a branch delay slot: EPC = pc-4, Cause.BD set, other Cause bits kept.
    present(1, 1, 5'd8, 32'h80000024, 1, 0, 32'h0, 0, 6'd0, 32'h0000FF01, 32'h00400000, 32'h0, a);
    push_w(5'd14, 32'h80000020, a + 1);
    push_w(5'd13, 32'h80400020, a + 2);
    push_w(5'd12, 32'h0000FF03, a + 3);
    push_r(32'hBFC00380, a + 4);
    run_seq(4, "bd_syscall");

    // Interrupt beats a simultaneous address error: code 0, no BadVAddr write.
    present(1, 1, 5'd4, 32'hBFC00400, 0, 1, 32'hDEAD0001, 0, 6'b000001, 32'h0000FF01, 32'h0000007C, 32'h0, a);
    push_w(5'd14, 32'hBFC00400, a + 1);
    push_w(5'd13, 32'h00000000, a + 2);
    push_w(5'd12, 32'h0000FF03, a + 3);
    push_r(32'hBFC00380, a + 4);
    run_seq(4, "interrupt");

    // No acceptance: IE clear, EXL set, or a bubble in MEM.
    present(1, 0, 5'd0, 32'h80000100, 0, 0, 32'h0, 0, 6'b000001, 32'h0000FF00, 32'h0, 32'h0, a);
    run_seq(0, "int_ie0");
    present(1, 0, 5'd0, 32'h80000100, 0, 0, 32'h0, 0, 6'b000001, 32'h0000FF03, 32'h0, 32'h0, a);
    run_seq(0, "int_exl1");
    present(0, 1, 5'd4, 32'h80000100, 0, 1, 32'h4, 1, 6'd0, 32'h0000FF01, 32'h0, 32'h0, a);
    run_seq(0, "bubble");

    // ERET: clear EXL, return to EPC.
    present(1, 0, 5'd0, 32'h80000300, 0, 0, 32'h0, 1, 6'd0, 32'h0000FF03, 32'h0, 32'hBFC00200, a);
    push_w(5'd12, 32'h0000FF01, a + 1);
    push_r(32'hBFC00200, a + 2);
    run_seq(2, "eret");

    // Exception and ERET together: exception wins.
    present(1, 1, 5'd10, 32'h80001000, 0, 0, 32'h0, 1, 6'd0, 32'h0000FF01, 32'h0, 32'hBFC00200, a);
    push_w(5'd14, 32'h80001000, a + 1);
    push_w(5'd13, 32'h00000028, a + 2);
    push_w(5'd12, 32'h0000FF03, a + 3);
    push_r(32'hBFC00380, a + 4);
    run_seq(4, "exc_vs_eret");

    // Nested exception (EXL set): EPC untouched, BD cleared in Cause.
    present(1, 1, 5'd12, 32'h80002000, 0, 0, 32'h0, 0, 6'd0, 32'h0000FF03, 32'h80000000, 32'h0, a);
    push_w(5'd13, 32'h00000030, a + 1);
    push_w(5'd12, 32'h0000FF03, a + 2);
    push_r(32'hBFC00380, a + 3);
    run_seq(3, "nested");

    // Reset while the Cause write is on the port.
    present(1, 1, 5'd5, 32'h80003000, 0, 1, 32'h00000001, 0, 6'd0, 32'h0000FF01, 32'h0, 32'h0, a);
    push_w(5'd8,  32'h00000001, a + 1);
    push_w(5'd14, 32'h80003000, a + 2);
    push_w(5'd13, 32'h00000014, a + 3);
    @(posedge clk); #1;
    clear_events();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_outs", {bus.cp0_we, bus.stall, bus.redirect_valid, bus.flush}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_sb_drained", sb.size(), 0);
    check("rst_mid_idle_stall", bus.stall, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exception_sequencer.md
Name: exception_sequencer

Overview:
- Exception/interrupt controller for the CP0 register block.
- Takes exception reports and ERET from the MEM stage, and pending interrupts from Status/Cause.
- Arbitrates between them and sequences the required CP0 writes over the single CP0 write port (we/waddr/wdata), one register per cycle.
- Stalls the pipeline while sequencing, then flushes it and redirects the PC to the handler vector or to EPC.

Parameters:
- EXC_VECTOR, 32'hBFC00380, handler entry address for all exceptions and interrupts.
- WIDTH, 32, data/address width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- inst_valid  in  1  a real (non-bubble) instruction occupies MEM.
- exc_valid  in  1  MEM instruction raised a synchronous exception.
- exc_code  in  5  ExcCode of that exception.
- exc_pc  in  WIDTH  PC of the MEM instruction.
- exc_bd  in  1  MEM instruction is in a branch delay slot.
- exc_has_badv  in  1  exception is an address error; BadVAddr must be written.
- exc_badvaddr  in  WIDTH  faulting virtual address.
- eret  in  1  MEM instruction is ERET.
- hw_int  in  6  hardware interrupt lines, level sensitive.
- status_in  in  WIDTH  current CP0 Status.
- cause_in  in  WIDTH  current CP0 Cause.
- epc_in  in  WIDTH  current CP0 EPC.
- cp0_we  out  1  CP0 write enable.
- cp0_waddr  out  5  CP0 register number: 8 BadVAddr, 12 Status, 13 Cause, 14 EPC.
- cp0_wdata  out  WIDTH  CP0 write data.
- stall  out  1  hold all pipeline stages.
- flush  out  1  kill IF..MEM contents.
- redirect_valid  out  1  load redirect_pc into the PC.
- redirect_pc  out  WIDTH  new fetch address.

Behaviour:
- Reset: state IDLE; all outputs 0; latched event registers 0.
- Interrupt pending (int_pend), combinational:
  - IP = {hw_int, cause_in[9:8]}.
  - int_pend = |(IP & status_in[15:8]) & status_in[0] & ~status_in[1].
- Acceptance in IDLE only, priority interrupt > exception > ERET:
  - Interrupt: int_pend & inst_valid. Latch code=0, pc=exc_pc, bd=exc_bd, has_badv=0.
  - Exception: exc_valid & inst_valid. Latch exc_code, exc_pc, exc_bd, exc_has_badv, exc_badvaddr.
  - ERET: eret & inst_valid & ~exc_valid. Latch epc_in as target.
  - The accepting cycle drives nothing; the first CP0 write happens in the next cycle.
- States:
  - IDLE.
  - W_BADV: we=1, addr 8, data=latched badvaddr.
  - W_EPC: we=1, addr 14, data = bd ? pc-4 : pc (mod 2^32).
  - W_CAUSE: we=1, addr 13, data = cause_in with [31]=bd, [6:2]=code, other bits unchanged.
  - W_STATUS: we=1, addr 12, data = status_in with bit1 (EXL) set.
  - E_STATUS: we=1, addr 12, data = status_in with bit1 cleared.
  - REDIRECT: we=0, flush=1, redirect_valid=1, redirect_pc = EXC_VECTOR or latched EPC target.
- Transitions:
  - Exception/interrupt: IDLE -> W_BADV (if has_badv) or W_EPC.
  - W_BADV -> W_EPC -> W_CAUSE -> W_STATUS -> REDIRECT -> IDLE.
  - ERET: IDLE -> E_STATUS -> REDIRECT -> IDLE.
- EXL already set at acceptance (status_in[1]=1, exception path): W_EPC is skipped, so EPC is preserved. Cause and Status are still written, and the redirect still goes to EXC_VECTOR.
- Latency:
  - Exception with BadVAddr: 5 cycles after acceptance to redirect; without: 4; EXL-set case: one fewer.
  - ERET: 2 cycles.
- stall = (state != IDLE); it is deasserted in the cycle after REDIRECT.
- Events arriving while not IDLE are ignored (the pipeline is stalled, so they are re-presented).
- Simultaneous exc_valid and eret: exception wins and ERET is dropped.
- Simultaneous interrupt and exception: interrupt wins; the exception is re-raised after the handler returns.
- Reset mid-sequence: returns to IDLE next cycle; no further CP0 writes; partial writes are not undone.
- cp0_we is never asserted in IDLE or REDIRECT.

Test Plan:
- Address error:
  - Stimulus: exc_valid, code=4, has_badv, badvaddr=0x00000013, pc=0xBFC00100, bd=0, status_in=0x0040FF01.
  - Expected writes: (8,0x13), (14,0xBFC00100), (13, code field 4), (12,0x0040FF03) on consecutive cycles.
  - Expected redirect: redirect to 0xBFC00380 with flush; stall high for 5 cycles.
- Delay-slot syscall:
  - Stimulus: code=8, pc=0x80000024, bd=1.
  - Expected: EPC write 0x80000020; Cause[31]=1, [6:2]=8; no BadVAddr write.
- Interrupt:
  - Stimulus: hw_int=6'b000001, status_in=0x0000FF01, inst_valid=1, exc_valid=1 same cycle.
  - Expected: Cause code 0 (interrupt wins).
  - Variant: IE=0 or EXL=1 -> no acceptance.
- ERET:
  - Stimulus: eret, epc_in=0xBFC00200, status_in=0x0000FF03.
  - Expected: single write (12,0x0000FF01), then redirect to 0xBFC00200.
- Nested exception:
  - Stimulus: exception with status_in[1]=1.
  - Expected: no addr-14 write; Cause and Status written; redirect to EXC_VECTOR.
- Reset mid-sequence:
  - Stimulus: rst asserted during W_CAUSE.
  - Expected: next cycle IDLE, cp0_we=0, stall=0, redirect_valid=0.
